vmm_acc_array: RTL and testbench
================================

Name: vmm_acc_array

Overview:
- Parametrised systolic vector-matrix multiply-accumulate array.
- Each accepted beat multiplies a TIN-element input vector by a TIN x TOUT weight tile.
- Per output channel, results are accumulated across a multi-beat group that ends on i_last.
- Data and weights are skewed together along the column chain, then deskewed, so all TOUT channel results leave aligned with a single valid pulse.
- Sits between the feature/weight buffers and the post-processing (requant/activation) stage.

Parameters:
- DW, 8, operand width in bits (data and weight).
- TIN, 8, input vector length (elements per dot product).
- TOUT, 8, output channel count (columns).
- ACC_W, 32, accumulator/output width per channel; must be >= 2*DW + clog2(TIN) + 1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- i_vld  input  1  input beat valid; no backpressure, one beat per cycle accepted.
- i_last  input  1  qualifies i_vld: beat closes the current accumulation group.
- i_signed  input  1  per-beat operand mode: 1 = two's complement, 0 = unsigned.
- i_dat  input  DW*TIN  input vector, element k at [k*DW +: DW].
- i_wt  input  DW*TIN*TOUT  weight tile; column j at [j*DW*TIN +: DW*TIN], same element order as i_dat.
- o_vld  output  1  one-cycle pulse per completed group.
- o_dat  output  ACC_W*TOUT  channel j result at [j*ACC_W +: ACC_W], signed.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset: all pipeline, skew, accumulator and deskew registers clear to 0; o_vld=0; o_dat=0.
- Skew: on the accepting edge, i_dat, i_wt, i_vld, i_last and i_signed are registered together.
  - Column j receives its data, its own weight slice and the control bits j cycles after column 0.
  - Weights skew with the data, so the caller presents weights in the same cycle as the data.
- Per column:
  - Stage A registers the dot product of TIN products.
  - Each product is formed at 2*DW bits: sign-extended if i_signed, zero-extended otherwise.
  - The sum is extended to ACC_W.
- Accumulate, stage B:
  - If the beat is valid and the column is "fresh" (after reset or after its previous last), acc = product; otherwise acc = acc + product. Wrap modulo 2^ACC_W unless the optional feature is enabled.
  - On a valid beat with last, the column result is captured and the column returns to fresh.
  - Non-valid cycles hold acc unchanged; gaps inside a group are allowed.
- Deskew:
  - Column j result and its done flag are delayed by TOUT-1-j cycles.
  - All columns are registered into o_dat together with o_vld.
- Latency: o_vld pulses exactly L = TOUT+2 cycles after the clk edge that accepted the i_last beat.
- Output hold: o_dat holds its value between pulses.
- Throughput:
  - Back-to-back single-beat groups (i_vld=i_last=1 every cycle) give o_vld high every cycle.
  - Each pulse carries exactly its own beat's result.
  - The first beat after a last always starts fresh, including in the very next cycle.
- i_last with i_vld=0 is ignored.
- i_signed applies only to the beat it accompanies. Mixed modes within a group are legal; products are summed as signed ACC_W values.
- Reset mid-group or mid-pipeline: all in-flight beats and partial sums are discarded. No o_vld results from pre-reset beats, and the next group starts fresh.

Optional Feature:
- Macro: VMM_ACC_SAT_EN.
- Defined: each accumulate step saturates to the signed ACC_W range, max 2^(ACC_W-1)-1 and min -2^(ACC_W-1). Once saturated, the value stays clamped unless later products move it back inside range.
- Undefined: two's-complement wrap. The saturation logic is absent.
- Latency is unchanged in both cases.

Test Plan:
All cases use DW=8, TIN=4, TOUT=4, ACC_W=24 unless stated.
1. Single beat unsigned: i_dat all 2, i_wt all 3, i_vld=i_last=1 -> o_vld pulse 6 cycles later, every channel = 24, o_vld low otherwise.
2. Signed vs unsigned: i_dat all 0xFF, column j weights all j+1, single beat.
   - i_signed=1 -> channel j = -4*(j+1).
   - i_signed=0 -> channel j = 1020*(j+1).
3. Multi-beat group with gaps: 3 beats of dat=1 and wt=1, with i_vld low for 2 cycles between beats, last on the third -> one o_vld 6 cycles after the third beat, all channels = 12.
4. Back-to-back groups: i_vld=i_last=1 for 4 consecutive cycles with dat=k (k=1..4) and wt=1 -> 4 consecutive o_vld pulses, channels = 4, 8, 12, 16 in order.
5. Reset mid-operation: 2 beats of a group, then rst_n low for 1 cycle, then a 1-beat group with dat=1, wt=1 -> exactly one o_vld, channels = 4, with no result from the pre-reset beats.
6. Saturation, ACC_W=19, signed: 5 beats of dat=0x7F, wt=0x7F.
   - With VMM_ACC_SAT_EN -> channels = 262143.
   - Without -> channels = -201708 (wrapped).

Source files
------------

// File: rtl/vmm_acc_array.sv
// Systolic vector-matrix multiply-accumulate array: skewed column chain, per-column accumulate, deskewed output.
// Optional macro VMM_ACC_SAT_EN selects saturating accumulation; default build wraps modulo 2^ACC_W.
module vmm_acc_array #(
    parameter int DW    = 8,
    parameter int TIN   = 8,
    parameter int TOUT  = 8,
    parameter int ACC_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_vld,
    input  logic                     i_last,
    input  logic                     i_signed,
    input  logic [DW*TIN-1:0]        i_dat,
    input  logic [DW*TIN*TOUT-1:0]   i_wt,
    output logic                     o_vld,
    output logic [ACC_W*TOUT-1:0]    o_dat
);
    localparam int VW = DW * TIN;

    logic [VW-1:0]    dat_q [TOUT];
    logic [VW-1:0]    dat_d [TOUT];
    logic [TOUT-1:0]  vld_q, vld_d, last_q, last_d, sgn_q, sgn_d;
    logic [ACC_W-1:0] col_res [TOUT];
    logic [TOUT-1:0]  col_done;
    logic             o_vld_q, o_vld_d;
    logic [ACC_W*TOUT-1:0] o_dat_q, o_dat_d;

    // Shared skew chain: stage k feeds column k, k cycles after the accepting edge
    always_comb begin
        dat_d[0]  = i_dat;
        vld_d[0]  = i_vld;
        last_d[0] = i_last;
        sgn_d[0]  = i_signed;
        for (int k = 1; k < TOUT; k++) begin
            dat_d[k]  = dat_q[k-1];
            vld_d[k]  = vld_q[k-1];
            last_d[k] = last_q[k-1];
            sgn_d[k]  = sgn_q[k-1];
        end
    end

    // Skew chain registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < TOUT; k++) dat_q[k] <= '0;
            vld_q  <= '0;
            last_q <= '0;
            sgn_q  <= '0;
        end else begin
            dat_q  <= dat_d;
            vld_q  <= vld_d;
            last_q <= last_d;
            sgn_q  <= sgn_d;
        end
    end

    for (genvar j = 0; j < TOUT; j++) begin : g_col
        localparam int DLY = TOUT - 1 - j;

        logic [VW-1:0]           wt_q [0:j];
        logic [VW-1:0]           wt_d [0:j];
        logic signed [DW:0]      ea_s [TIN];
        logic signed [DW:0]      eb_s [TIN];
        logic signed [2*DW+1:0]  prod_s [TIN];
        logic signed [ACC_W-1:0] pext_s [TIN];
        logic [ACC_W-1:0]        dot_d, dot_q, acc_d, acc_q, res_d, res_q, base_s, sum_s;
        logic                    av_d, av_q, al_d, al_q, open_d, open_q, done_d, done_q;
`ifdef VMM_ACC_SAT_EN
        localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
        localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
        logic [ACC_W:0] wide_s;
`endif

        // Weight slice travels with its column's data; stage j lines up with dat_q[j]
        always_comb begin
            wt_d[0] = i_wt[j*VW +: VW];
            for (int m = 1; m <= j; m++) wt_d[m] = wt_q[m-1];
        end

        // Stage A: dot product of TIN products, each sign- or zero-extended by the beat's mode
        always_comb begin
            dot_d = '0;
            for (int k = 0; k < TIN; k++) begin
                ea_s[k]   = $signed({sgn_q[j] & dat_q[j][k*DW+DW-1], dat_q[j][k*DW +: DW]});
                eb_s[k]   = $signed({sgn_q[j] & wt_q[j][k*DW+DW-1], wt_q[j][k*DW +: DW]});
                prod_s[k] = $signed({{(DW+1){ea_s[k][DW]}}, ea_s[k]})
                          * $signed({{(DW+1){eb_s[k][DW]}}, eb_s[k]});
                pext_s[k] = ACC_W'(prod_s[k]);
                dot_d     = dot_d + pext_s[k];
            end
            av_d = vld_q[j];
            al_d = vld_q[j] & last_q[j];
        end

        // Stage B: accumulate; a closed group restarts from zero on its next valid beat
        always_comb begin
            acc_d  = acc_q;
            res_d  = res_q;
            open_d = open_q;
            done_d = 1'b0;
            base_s = open_q ? acc_q : '0;
`ifdef VMM_ACC_SAT_EN
            wide_s = {base_s[ACC_W-1], base_s} + {dot_q[ACC_W-1], dot_q};
            if (wide_s[ACC_W] != wide_s[ACC_W-1]) begin
                sum_s = wide_s[ACC_W] ? SAT_MIN : SAT_MAX;
            end else begin
                sum_s = wide_s[ACC_W-1:0];
            end
`else
            sum_s = base_s + dot_q;
`endif
            if (av_q) begin
                acc_d = sum_s;
                if (al_q) begin
                    res_d  = sum_s;
                    done_d = 1'b1;
                    open_d = 1'b0;
                end else begin
                    open_d = 1'b1;
                end
            end else begin
                acc_d = acc_q;
            end
        end

        // Column pipeline registers
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int m = 0; m <= j; m++) wt_q[m] <= '0;
                dot_q  <= '0;
                av_q   <= 1'b0;
                al_q   <= 1'b0;
                acc_q  <= '0;
                res_q  <= '0;
                open_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                wt_q   <= wt_d;
                dot_q  <= dot_d;
                av_q   <= av_d;
                al_q   <= al_d;
                acc_q  <= acc_d;
                res_q  <= res_d;
                open_q <= open_d;
                done_q <= done_d;
            end
        end

        if (DLY == 0) begin : g_nodly
            assign col_res[j]  = res_q;
            assign col_done[j] = done_q;
        end else begin : g_dly
            logic [ACC_W-1:0] dres_q [DLY];
            logic [ACC_W-1:0] dres_d [DLY];
            logic [DLY-1:0]   ddone_q, ddone_d;

            // Deskew line: earlier columns wait for the last column to finish
            always_comb begin
                dres_d[0]  = res_q;
                ddone_d[0] = done_q;
                for (int m = 1; m < DLY; m++) begin
                    dres_d[m]  = dres_q[m-1];
                    ddone_d[m] = ddone_q[m-1];
                end
            end

            // Deskew registers
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int m = 0; m < DLY; m++) dres_q[m] <= '0;
                    ddone_q <= '0;
                end else begin
                    dres_q  <= dres_d;
                    ddone_q <= ddone_d;
                end
            end

            assign col_res[j]  = dres_q[DLY-1];
            assign col_done[j] = ddone_q[DLY-1];
        end
    end

    // Output capture: all columns arrive aligned; o_dat holds between pulses
    always_comb begin
        o_vld_d = &col_done;
        o_dat_d = o_dat_q;
        if (o_vld_d) begin
            for (int j = 0; j < TOUT; j++) o_dat_d[j*ACC_W +: ACC_W] = col_res[j];
        end else begin
            o_dat_d = o_dat_q;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_vld_q <= 1'b0;
            o_dat_q <= '0;
        end else begin
            o_vld_q <= o_vld_d;
            o_dat_q <= o_dat_d;
        end
    end

    assign o_vld = o_vld_q;
    assign o_dat = o_dat_q;
endmodule

// File: tb/tb_vmm_acc_array.sv
// Directed bench for vmm_acc_array (DW=8, TIN=4, TOUT=4, ACC_W=19) with a queue scoreboard fed by an integer model.
module tb_vmm_acc_array;
    localparam int DW = 8, TIN = 4, TOUT = 4, ACC_W = 19, LAT = 6;
    localparam longint MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_W-1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_vld = 1'b0, i_last = 1'b0, i_signed = 1'b0;
    logic [DW*TIN-1:0] i_dat = '0;
    logic [DW*TIN*TOUT-1:0] i_wt = '0;
    logic o_vld;
    logic [ACC_W*TOUT-1:0] o_dat;

    typedef struct { int due; logic [ACC_W*TOUT-1:0] val; } exp_t;
    exp_t sb_q [$];
    int checks = 0, errors = 0, cyc = 0;
    longint macc [TOUT];
    bit mopen [TOUT];
    logic [ACC_W*TOUT-1:0] last_out = '0;

    vmm_acc_array #(.DW(DW), .TIN(TIN), .TOUT(TOUT), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_last(i_last), .i_signed(i_signed),
        .i_dat(i_dat), .i_wt(i_wt), .o_vld(o_vld), .o_dat(o_dat));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [ACC_W*TOUT-1:0] got, input logic [ACC_W*TOUT-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint fix(input longint v);
`ifdef VMM_ACC_SAT_EN
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
`else
        longint m;
        m = v & ((longint'(1) <<< ACC_W) - 1);
        if (m > MAXV) m = m - (longint'(1) <<< ACC_W);
        return m;
`endif
    endfunction

    function automatic longint elem(input logic [7:0] x, input logic s);
        if (s) return longint'($signed(x));
        else return longint'({56'd0, x});
    endfunction

    function automatic logic [DW*TIN-1:0] rep(input logic [7:0] b);
        logic [DW*TIN-1:0] d;
        for (int k = 0; k < TIN; k++) d[k*DW +: DW] = b;
        return d;
    endfunction

    function automatic logic [DW*TIN*TOUT-1:0] wcols(input logic [31:0] cb);
        logic [DW*TIN*TOUT-1:0] w;
        for (int j = 0; j < TOUT; j++)
            for (int k = 0; k < TIN; k++) w[j*DW*TIN + k*DW +: DW] = cb[j*8 +: 8];
        return w;
    endfunction

    // One cycle of stimulus; valid beats update the model and closing beats queue a result
    task automatic drive(input logic v, input logic l, input logic s,
                         input logic [DW*TIN-1:0] d, input logic [DW*TIN*TOUT-1:0] w);
        exp_t e;
        longint dot;
        @(negedge clk);
        rst_n = 1'b1;
        i_vld = v; i_last = l; i_signed = s; i_dat = d; i_wt = w;
        if (v) begin
            e.due = cyc + 1 + LAT;
            e.val = '0;
            for (int j = 0; j < TOUT; j++) begin
                dot = 0;
                for (int k = 0; k < TIN; k++)
                    dot = dot + elem(d[k*DW +: DW], s) * elem(w[j*DW*TIN + k*DW +: DW], s);
                macc[j] = fix((mopen[j] ? macc[j] : 0) + dot);
                if (l) begin
                    mopen[j] = 1'b0;
                    e.val[j*ACC_W +: ACC_W] = macc[j][ACC_W-1:0];
                end else begin
                    mopen[j] = 1'b1;
                end
            end
            if (l) sb_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; i_vld = 1'b0; i_last = 1'b0;
        @(posedge clk);
        #1;
        sb_q.delete();
        last_out = '0;
        for (int j = 0; j < TOUT; j++) begin macc[j] = 0; mopen[j] = 1'b0; end
    endtask

    // Scoreboard: pulse exactly when due with the queued result, otherwise low with o_dat held
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("o_vld_pulse", {75'd0, o_vld}, {75'd0, 1'b1});
            chk("o_dat", o_dat, e.val);
            last_out = e.val;
        end else begin
            chk("o_vld_idle", {75'd0, o_vld}, {75'd0, 1'b0});
            chk("o_dat_hold", o_dat, last_out);
        end
    end

    initial begin
        logic [DW*TIN-1:0] rd;
        logic [DW*TIN*TOUT-1:0] rw;
        logic rs;
        for (int j = 0; j < TOUT; j++) begin macc[j] = 0; mopen[j] = 1'b0; end
        repeat (3) @(negedge clk);
        // single beat unsigned: 4*2*3 = 24
        drive(1'b1, 1'b1, 1'b0, rep(8'h02), wcols(32'h03030303));
        idle(8);
        // signed then unsigned 0xFF with column weights j+1
        drive(1'b1, 1'b1, 1'b1, rep(8'hFF), wcols(32'h04030201));
        drive(1'b1, 1'b1, 1'b0, rep(8'hFF), wcols(32'h04030201));
        idle(8);
        // multi-beat group with gaps: 12
        drive(1'b1, 1'b0, 1'b0, rep(8'h01), wcols(32'h01010101));
        idle(2);
        drive(1'b1, 1'b0, 1'b0, rep(8'h01), wcols(32'h01010101));
        idle(2);
        drive(1'b1, 1'b1, 1'b0, rep(8'h01), wcols(32'h01010101));
        idle(8);
        // back-to-back single-beat groups: 4, 8, 12, 16
        for (int k = 1; k <= 4; k++) drive(1'b1, 1'b1, 1'b0, rep(8'(k)), wcols(32'h01010101));
        idle(8);
        // last without valid is ignored
        drive(1'b1, 1'b0, 1'b0, rep(8'h03), wcols(32'h01020304));
        drive(1'b0, 1'b1, 1'b0, rep(8'h05), wcols(32'h05050505));
        drive(1'b1, 1'b1, 1'b0, rep(8'h02), wcols(32'h01010101));
        idle(8);
        // random mixed-mode group
        for (int b = 0; b < 3; b++) begin
            rd = {$urandom(), $urandom()} >> 32;
            for (int q = 0; q < 4; q++) rw[q*32 +: 32] = $urandom();
            rs = 1'($urandom_range(1, 0));
            drive(1'b1, 1'(b == 2), rs, rd, rw);
        end
        idle(8);
        // reset mid-group, then a fresh one-beat group: 4
        drive(1'b1, 1'b0, 1'b0, rep(8'h01), wcols(32'h01010101));
        drive(1'b1, 1'b0, 1'b0, rep(8'h01), wcols(32'h01010101));
        do_reset();
        drive(1'b1, 1'b1, 1'b0, rep(8'h01), wcols(32'h01010101));
        idle(8);
        // a closed group still in flight at reset yields no pulse
        drive(1'b1, 1'b1, 1'b0, rep(8'h07), wcols(32'h01010101));
        do_reset();
        idle(8);
        // saturation / wrap: 5 signed beats of 0x7F
        for (int b = 0; b < 5; b++) drive(1'b1, 1'(b == 4), 1'b1, rep(8'h7F), wcols(32'h7F7F7F7F));
        idle(10);
        chk("drain", 76'(sb_q.size()), 76'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
